// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_if
//  Description : Bundle of all non-clock signals around mem_port_arbiter.
//                Fetch side : if_req, if_addr -> if_ready, if_rdata, stall_if
//                Data side  : dm_req, dm_we, dm_byte, dm_addr, dm_wdata
//                             -> dm_ready, dm_rdata, stall_dm
//                Memory side: mem_en, mem_we, mem_byte, mem_addr, mem_wdata
//                             <- mem_rdata
//                slave  : view taken by the arbiter
//                master : view taken by requesters / memory model
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;

    logic        dm_req;
    logic        dm_we;
    logic        dm_byte;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ready;
    logic [31:0] dm_rdata;

    logic        mem_en;
    logic        mem_we;
    logic        mem_byte;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        stall_if;
    logic        stall_dm;

    modport slave (
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_byte, dm_addr, dm_wdata,
        input  mem_rdata,
        output if_ready, if_rdata,
        output dm_ready, dm_rdata,
        output mem_en, mem_we, mem_byte, mem_addr, mem_wdata,
        output stall_if, stall_dm
    );

    modport master (
        output if_req, if_addr,
        output dm_req, dm_we, dm_byte, dm_addr, dm_wdata,
        output mem_rdata,
        input  if_ready, if_rdata,
        input  dm_ready, dm_rdata,
        input  mem_en, mem_we, mem_byte, mem_addr, mem_wdata,
        input  stall_if, stall_dm
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-ported fixed-latency memory between the
//                instruction fetch port (I) and the data-memory port (D).
//                Each access runs IDLE -> ACCESS (LATENCY cycles) -> RESP.
//                D has priority, but after MAX_STREAK consecutive D grants
//                made while I was waiting, I is forced in.
//  Ports       : clock - system clock (rising edge)
//                reset - synchronous, active-high
//                bus   - mem_port_arbiter_if.slave (requesters + memory)
//  Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int LATENCY    = 2,
    parameter int MAX_STREAK = 4
) (
    input wire                 clock,
    input wire                 reset,
    mem_port_arbiter_if.slave  bus
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int STK_W = $clog2(MAX_STREAK + 1);

    localparam logic [CNT_W-1:0] c_cnt_init   = CNT_W'(LATENCY - 1);
    localparam logic [STK_W-1:0] c_streak_max = STK_W'(MAX_STREAK);

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_access = 2'd1;
    localparam logic [1:0] c_resp   = 2'd2;

    logic [1:0]       r_state;
    logic             r_owner_d;     // 1: current access belongs to D
    logic             r_we;
    logic             r_byte;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [CNT_W-1:0] r_cnt;
    logic [STK_W-1:0] r_streak;
    logic [31:0]      r_if_rdata;
    logic [31:0]      r_dm_rdata;

    logic w_grant_d;
    logic w_grant_i;
    logic w_access;
    logic w_if_ready;
    logic w_dm_ready;

    // D wins unless I has already been passed over MAX_STREAK times.
    assign w_grant_d = bus.dm_req & ~(bus.if_req & (r_streak == c_streak_max));
    assign w_grant_i = bus.if_req & ~w_grant_d;

    assign w_access   = (r_state == c_access);
    assign w_if_ready = (r_state == c_resp) & ~r_owner_d;
    assign w_dm_ready = (r_state == c_resp) &  r_owner_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= c_idle;
            r_owner_d  <= 1'b0;
            r_we       <= 1'b0;
            r_byte     <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_cnt      <= '0;
            r_streak   <= '0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_grant_d || w_grant_i) begin
                        r_owner_d <= w_grant_d;
                        r_cnt     <= c_cnt_init;
                        r_state   <= c_access;
                        if (w_grant_d) begin
                            r_we    <= bus.dm_we;
                            r_byte  <= bus.dm_byte;
                            r_addr  <= bus.dm_addr;
                            r_wdata <= bus.dm_wdata;
                            // Streak only grows while I is actually waiting.
                            if (!bus.if_req) begin
                                r_streak <= '0;
                            end else if (r_streak != c_streak_max) begin
                                r_streak <= r_streak + 1'b1;
                            end
                        end else begin
                            r_we     <= 1'b0;
                            r_byte   <= 1'b0;
                            r_addr   <= bus.if_addr;
                            r_wdata  <= '0;
                            r_streak <= '0;
                        end
                    end
                end
                c_access: begin
                    if (r_cnt == '0) begin
                        // Memory data is valid in the last access cycle.
                        if (r_owner_d) begin
                            r_dm_rdata <= r_we ? 32'd0 : bus.mem_rdata;
                        end else begin
                            r_if_rdata <= bus.mem_rdata;
                        end
                        r_state <= c_resp;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_resp:  r_state <= c_idle;
                default: r_state <= c_idle;
            endcase
        end
    end

    // Command is only presented during ACCESS; zero otherwise.
    assign bus.mem_en    = w_access;
    assign bus.mem_we    = w_access & r_we;
    assign bus.mem_byte  = w_access & r_byte;
    assign bus.mem_addr  = w_access ? r_addr  : 32'd0;
    assign bus.mem_wdata = w_access ? r_wdata : 32'd0;

    assign bus.if_ready  = w_if_ready;
    assign bus.dm_ready  = w_dm_ready;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.dm_rdata  = r_dm_rdata;

    assign bus.stall_if  = bus.if_req & ~w_if_ready;
    assign bus.stall_dm  = bus.dm_req & ~w_dm_ready;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter. A transaction-level
//                model (grant cycle + fixed offsets) predicts every output on
//                every cycle; directed sequences pin the model with literal
//                values, then randomized requesters exercise it.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int LAT = 2;
    localparam int MS  = 4;

    logic clock = 1'b0;
    logic reset;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.LATENCY(LAT), .MAX_STREAK(MS)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting for DUT (t=%0t)", nm, $time);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    // An access granted in cycle g drives the memory in g+1..g+LAT, data is
    // taken at g+LAT, ready pulses at g+LAT+1, and arbitration resumes after.
    logic        m_valid = 1'b0;
    logic        m_active;
    int          m_g;
    logic        m_owner_d;
    logic        m_we, m_byte;
    logic [31:0] m_addr, m_wdata;
    int          m_streak;
    logic [31:0] m_if_rdata, m_dm_rdata;
    logic        if_seen = 1'b0;
    logic        dm_seen = 1'b0;

    always @(negedge clock) begin
        int   k;
        logic e_en, e_rdy, gd;
        k     = cyc - m_g;
        e_en  = m_active && (k >= 1) && (k <= LAT);
        e_rdy = m_active && (k == LAT + 1);
        if (m_valid) begin
            chk("mem_en",    {31'd0, bus.mem_en},   {31'd0, e_en});
            chk("mem_we",    {31'd0, bus.mem_we},   {31'd0, e_en & m_we});
            chk("mem_byte",  {31'd0, bus.mem_byte}, {31'd0, e_en & m_byte});
            chk("mem_addr",  bus.mem_addr,  e_en ? m_addr  : 32'd0);
            chk("mem_wdata", bus.mem_wdata, e_en ? m_wdata : 32'd0);
            chk("if_ready",  {31'd0, bus.if_ready}, {31'd0, e_rdy & ~m_owner_d});
            chk("dm_ready",  {31'd0, bus.dm_ready}, {31'd0, e_rdy &  m_owner_d});
            chk("if_rdata",  bus.if_rdata, m_if_rdata);
            chk("dm_rdata",  bus.dm_rdata, m_dm_rdata);
            chk("stall_if",  {31'd0, bus.stall_if}, {31'd0, bus.if_req & ~(e_rdy & ~m_owner_d)});
            chk("stall_dm",  {31'd0, bus.stall_dm}, {31'd0, bus.dm_req & ~(e_rdy &  m_owner_d)});
        end
        if_seen = bus.if_ready;
        dm_seen = bus.dm_ready;

        if (reset) begin
            m_valid    = 1'b1;
            m_active   = 1'b0;
            m_g        = 0;
            m_owner_d  = 1'b0;
            m_streak   = 0;
            m_if_rdata = 32'd0;
            m_dm_rdata = 32'd0;
        end else if (m_valid) begin
            if (m_active) begin
                if (k == LAT) begin
                    if (m_owner_d) m_dm_rdata = m_we ? 32'd0 : bus.mem_rdata;
                    else           m_if_rdata = bus.mem_rdata;
                end
                if (k == LAT + 1) m_active = 1'b0;
            end else if (bus.dm_req || bus.if_req) begin
                gd        = bus.dm_req && !(bus.if_req && m_streak == MS);
                m_active  = 1'b1;
                m_g       = cyc;
                m_owner_d = gd;
                if (gd) begin
                    m_we     = bus.dm_we;
                    m_byte   = bus.dm_byte;
                    m_addr   = bus.dm_addr;
                    m_wdata  = bus.dm_wdata;
                    m_streak = bus.if_req ? ((m_streak < MS) ? m_streak + 1 : MS) : 0;
                end else begin
                    m_we     = 1'b0;
                    m_byte   = 1'b0;
                    m_addr   = bus.if_addr;
                    m_wdata  = 32'd0;
                    m_streak = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        string      es;
        logic [7:0] got [10];
        int         n, en_cnt, rdy_cnt;
        logic       ok;

        reset = 1'b1;
        bus.if_req = 0; bus.if_addr = 0;
        bus.dm_req = 0; bus.dm_we = 0; bus.dm_byte = 0; bus.dm_addr = 0; bus.dm_wdata = 0;
        bus.mem_rdata = 0;
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("reset_mem_en",   {31'd0, bus.mem_en}, 32'd0);
        chk("reset_if_rdata", bus.if_rdata, 32'd0);

        // Fetch read, literal timing.
        bus.if_req = 1; bus.if_addr = 32'h40; bus.mem_rdata = 32'h8C220004;
        step();
        chk("t1_en_c1",   {31'd0, bus.mem_en}, 32'd1);
        chk("t1_addr_c1", bus.mem_addr, 32'h40);
        chk("t1_we_c1",   {31'd0, bus.mem_we}, 32'd0);
        step();
        chk("t1_en_c2",   {31'd0, bus.mem_en}, 32'd1);
        step();
        chk("t1_ready",   {31'd0, bus.if_ready}, 32'd1);
        chk("t1_rdata",   bus.if_rdata, 32'h8C220004);
        bus.if_req = 0;
        step();
        chk("t1_ready_off", {31'd0, bus.if_ready}, 32'd0);
        chk("t1_rdata_hold", bus.if_rdata, 32'h8C220004);

        // Byte write from D, literal timing.
        bus.dm_req = 1; bus.dm_we = 1; bus.dm_byte = 1; bus.dm_addr = 32'h10; bus.dm_wdata = 32'hAB;
        bus.mem_rdata = 32'hDEADBEEF;
        #1;
        chk("t2_stall_c0", {31'd0, bus.stall_dm}, 32'd1);
        for (int i = 1; i <= LAT; i++) begin
            step();
            chk("t2_we",    {31'd0, bus.mem_we},   32'd1);
            chk("t2_byte",  {31'd0, bus.mem_byte}, 32'd1);
            chk("t2_wdata", bus.mem_wdata, 32'hAB);
            chk("t2_stall", {31'd0, bus.stall_dm}, 32'd1);
        end
        step();
        chk("t2_ready", {31'd0, bus.dm_ready}, 32'd1);
        chk("t2_rdata", bus.dm_rdata, 32'd0);
        chk("t2_stall_off", {31'd0, bus.stall_dm}, 32'd0);
        bus.dm_req = 0; bus.dm_we = 0; bus.dm_byte = 0;
        repeat (2) step();

        // Both requesters held: D first, streak of MS, then I; twice.
        es = "DDDDIDDDDI";
        bus.if_req = 1; bus.if_addr = 32'h100;
        bus.dm_req = 1; bus.dm_addr = 32'h200;
        n = 0;
        for (int c = 0; c < 200 && n < 10; c++) begin
            step();
            if (dm_seen) begin got[n] = "D"; n++; bus.dm_addr = bus.dm_addr + 4; end
            if (if_seen) begin got[n] = "I"; n++; bus.if_addr = bus.if_addr + 4; end
        end
        if (n < 10) timeout("streak_order");
        else for (int i = 0; i < 10; i++) chk("streak_order", {24'd0, got[i]}, {24'd0, es[i]});
        bus.if_req = 0; bus.dm_req = 0;
        repeat (LAT + 3) step();

        // Reset in the first access cycle of a D read.
        bus.mem_rdata = 32'h12345678;
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h20;
        step();
        chk("t5_en_before", {31'd0, bus.mem_en}, 32'd1);
        reset = 1;
        step();
        reset = 0;
        chk("t5_en_after",  {31'd0, bus.mem_en}, 32'd0);
        chk("t5_rdata_clr", bus.dm_rdata, 32'd0);
        for (int i = 0; i < LAT; i++) begin
            step();
            chk("t5_no_ready", {31'd0, bus.dm_ready}, 32'd0);
        end
        step();
        chk("t5_reissue_ready", {31'd0, bus.dm_ready}, 32'd1);
        chk("t5_reissue_rdata", bus.dm_rdata, 32'h12345678);
        bus.dm_req = 0;
        repeat (2) step();

        // D drops its request mid-access.
        bus.dm_req = 1; bus.dm_addr = 32'h30;
        step();
        bus.dm_req = 0;
        en_cnt = 0; rdy_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.mem_en)   en_cnt++;
            if (bus.dm_ready) rdy_cnt++;
            step();
        end
        chk("t6_ready_count", rdy_cnt, 1);
        chk("t6_en_count",    en_cnt,  LAT);

        // Randomized requesters against the model.
        for (int c = 0; c < 3000; c++) begin
            bus.mem_rdata = $urandom;
            reset = ($urandom_range(0, 299) == 0);
            if (bus.if_req && if_seen) begin
                bus.if_req  = $urandom_range(0, 1);
                bus.if_addr = $urandom;
            end else if (!bus.if_req && $urandom_range(0, 2) == 0) begin
                bus.if_req  = 1;
                bus.if_addr = $urandom;
            end else if (bus.if_req && $urandom_range(0, 49) == 0) begin
                bus.if_req  = 0;
            end
            ok = (bus.dm_req && dm_seen) || (!bus.dm_req && $urandom_range(0, 2) == 0);
            if (ok) begin
                bus.dm_req   = $urandom_range(0, 1);
                bus.dm_we    = $urandom_range(0, 1);
                bus.dm_byte  = $urandom_range(0, 1);
                bus.dm_addr  = $urandom;
                bus.dm_wdata = $urandom;
            end else if (bus.dm_req && $urandom_range(0, 49) == 0) begin
                bus.dm_req = 0;
            end
            step();
        end
        reset = 0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
